// File: rtl/fetch_target_queue_pkg.sv
// Shared types for the fetch target queue.
//   bpu_predict_t : prediction attached to a fetch group by the branch predictor
//   ftq_entry_t   : one stored fetch group {pc, slot mask, prediction}
//   FTQ_DEPTH     : default queue depth
package fetch_target_queue_pkg;

  localparam int FTQ_DEPTH = 8;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bpu_predict_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [1:0]   mask;
    bpu_predict_t predict;
  } ftq_entry_t;

endpackage

// File: rtl/fetch_target_queue_ram.sv
// Flop-based entry storage for the fetch target queue.
//   clk        clock
//   we_i       write enable
//   waddr_i    write index
//   wdata_i    entry to write
//   raddr_a_i  / rdata_a_o  async read port (issue side)
//   raddr_b_i  / rdata_b_o  async read port (retire side)
// Contents are never cleared; validity is tracked by the owner's pointers.
module fetch_target_queue_ram
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ftq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output ftq_entry_t    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output ftq_entry_t    rdata_b_o
);

  ftq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: decouples branch predictor from the I-cache.
// Predicted fetch groups are pushed at tail, issued in order to the I-cache
// at issue, and retired in order at head as I-cache responses return.
// A flush drops every entry; responses still owed for already-issued
// requests are counted in discard_q and swallowed when they arrive.
//   clk, rst_n     clock, synchronous active-low reset
//   flush_i        drop all entries
//   bpu_pc_i       group pc (8-byte group, pc[2] selects first slot)
//   bpu_valid_i    per-slot valid; any set bit pushes a group
//   bpu_predict_i  prediction for the group
//   bpu_stall_o    queue full
//   req_valid_o / req_ready_i / req_pc_o   I-cache request
//   resp_valid_i   I-cache response for the oldest outstanding request
//   out_valid_o / out_pc_o / out_mask_o / out_predict_o   retiring group
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic [31:0]  bpu_pc_i,
  input  logic [1:0]   bpu_valid_i,
  input  bpu_predict_t bpu_predict_i,
  output logic         bpu_stall_o,
  output logic         req_valid_o,
  input  logic         req_ready_i,
  output logic [31:0]  req_pc_o,
  input  logic         resp_valid_i,
  output logic         out_valid_o,
  output logic [31:0]  out_pc_o,
  output logic [1:0]   out_mask_o,
  output bpu_predict_t out_predict_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d;
  logic [PW-1:0] disc_q, disc_d;
  logic [PW-1:0] count, inflight;
  logic [PW:0]   occ;
  logic          full, push, fire, retire, disc_resp;
  ftq_entry_t    wdata, issue_ent, head_ent;

  assign count    = tail_q - head_q;
  assign inflight = issue_q - head_q;
  // Outstanding I-cache requests, live plus abandoned by a flush.
  assign occ      = {1'b0, disc_q} + {1'b0, inflight};
  // Full is from registers only: a same-cycle retire frees its slot next cycle.
  assign full     = (count == DEPTH_P);

  assign push      = (|bpu_valid_i) && !full && !flush_i;
  assign fire      = req_valid_o && req_ready_i;
  assign disc_resp = resp_valid_i && (disc_q != '0);
  assign retire    = resp_valid_i && (disc_q == '0) && (inflight != '0) && !flush_i;

  assign bpu_stall_o = full;
  // issue_q reads registered tail, so a group is issuable the cycle after its push.
  assign req_valid_o = (issue_q != tail_q) && (occ < {1'b0, DEPTH_P}) && !flush_i;
  assign req_pc_o    = issue_ent.pc;

  assign out_valid_o   = retire;
  assign out_pc_o      = head_ent.pc;
  assign out_mask_o    = head_ent.mask;
  assign out_predict_o = head_ent.predict;

  assign wdata = '{pc: bpu_pc_i, mask: bpu_valid_i, predict: bpu_predict_i};

  fetch_target_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .we_i      (push),
    .waddr_i   (tail_q[AW-1:0]),
    .wdata_i   (wdata),
    .raddr_a_i (issue_q[AW-1:0]),
    .rdata_a_o (issue_ent),
    .raddr_b_i (head_q[AW-1:0]),
    .rdata_b_o (head_ent)
  );

  always_comb begin
    head_d  = head_q;
    issue_d = issue_q;
    tail_d  = tail_q;
    disc_d  = disc_q;
    if (flush_i) begin
      head_d  = '0;
      issue_d = '0;
      tail_d  = '0;
      // Every live in-flight request becomes a discard; a response this
      // cycle settles one of the outstanding ones whichever kind it is.
      disc_d  = disc_q + inflight - PW'(resp_valid_i && (occ != '0));
    end else begin
      if (push)      tail_d  = tail_q + 1'b1;
      if (fire)      issue_d = issue_q + 1'b1;
      if (retire)    head_d  = head_q + 1'b1;
      if (disc_resp) disc_d  = disc_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      issue_q <= '0;
      tail_q  <= '0;
      disc_q  <= '0;
    end else begin
      head_q  <= head_d;
      issue_q <= issue_d;
      tail_q  <= tail_d;
      disc_q  <= disc_d;
    end
  end

  // A response with nothing outstanding is ignored by the logic above.
  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_i |-> (occ != '0));

endmodule

// File: tb/tb_fetch_target_queue.sv
module tb_fetch_target_queue;
  import fetch_target_queue_pkg::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic [31:0]  bpu_pc_i;
  logic [1:0]   bpu_valid_i;
  bpu_predict_t bpu_predict_i;
  logic         bpu_stall_o;
  logic         req_valid_o;
  logic         req_ready_i;
  logic [31:0]  req_pc_o;
  logic         resp_valid_i;
  logic         out_valid_o;
  logic [31:0]  out_pc_o;
  logic [1:0]   out_mask_o;
  bpu_predict_t out_predict_o;

  fetch_target_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .bpu_pc_i(bpu_pc_i), .bpu_valid_i(bpu_valid_i), .bpu_predict_i(bpu_predict_i),
    .bpu_stall_o(bpu_stall_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_pc_o(req_pc_o),
    .resp_valid_i(resp_valid_i),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_mask_o(out_mask_o),
    .out_predict_o(out_predict_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / reference: queued groups in push order, count of live
  // issued requests, count of responses owed for flushed requests.
  ftq_entry_t exp_q[$];
  int tb_infl = 0;
  int tb_disc = 0;

  always @(negedge clk) begin
    bit e_full, e_req, e_out;
    if (!rst_n) begin
      exp_q.delete();
      tb_infl = 0;
      tb_disc = 0;
    end else begin
      e_full = (exp_q.size() == DEPTH);
      e_req  = (tb_infl < exp_q.size()) && (tb_disc + tb_infl < DEPTH) && !flush_i;
      e_out  = resp_valid_i && (tb_disc == 0) && (tb_infl > 0) && !flush_i;
      chk("sb_stall", 64'(bpu_stall_o), 64'(e_full));
      chk("sb_req_valid", 64'(req_valid_o), 64'(e_req));
      if (e_req && req_valid_o) chk("sb_req_pc", 64'(req_pc_o), 64'(exp_q[tb_infl].pc));
      chk("sb_out_valid", 64'(out_valid_o), 64'(e_out));
      if (e_out && out_valid_o) begin
        chk("sb_out_pc", 64'(out_pc_o), 64'(exp_q[0].pc));
        chk("sb_out_mask", 64'(out_mask_o), 64'(exp_q[0].mask));
        chk("sb_out_pred", 64'(out_predict_o), 64'(exp_q[0].predict));
      end
      if (flush_i) begin
        tb_disc = tb_disc + tb_infl - ((resp_valid_i && (tb_disc + tb_infl > 0)) ? 1 : 0);
        tb_infl = 0;
        exp_q.delete();
      end else begin
        if (resp_valid_i) begin
          if (tb_disc > 0) tb_disc--;
          else if (tb_infl > 0) begin
            tb_infl--;
            void'(exp_q.pop_front());
          end
        end
        if (e_req && req_ready_i) tb_infl++;
        if ((|bpu_valid_i) && !e_full)
          exp_q.push_back('{pc: bpu_pc_i, mask: bpu_valid_i, predict: bpu_predict_i});
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] m);
    bpu_pc_i = pc;
    bpu_valid_i = m;
    bpu_predict_i = '{taken: pc[3], target: pc + 32'h40};
    next();
    bpu_valid_i = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    bpu_valid_i = 2'b00;
    flush_i = 1'b0;
    while ((exp_q.size() != 0 || tb_disc + tb_infl != 0) && n < 200) begin
      req_ready_i = 1'b1;
      resp_valid_i = (tb_disc + tb_infl) != 0;
      next();
      n++;
    end
    req_ready_i = 1'b0;
    resp_valid_i = 1'b0;
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout left=%0d outstanding=%0d", exp_q.size(), tb_disc + tb_infl);
    end
  endtask

  typedef struct {
    logic [31:0]  pc;
    logic [1:0]   mask;
    bpu_predict_t pred;
    logic [31:0]  exp_req_pc;
    logic [31:0]  exp_out_pc;
    logic [1:0]   exp_out_mask;
    bpu_predict_t exp_out_pred;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{32'h1c000000, 2'b11, '{1'b0, 32'h0},        32'h1c000000, 32'h1c000000, 2'b11, '{1'b0, 32'h0}};
    vt[1] = '{32'h1c000004, 2'b10, '{1'b1, 32'h1c000200}, 32'h1c000004, 32'h1c000004, 2'b10, '{1'b1, 32'h1c000200}};
    vt[2] = '{32'h80000008, 2'b01, '{1'b1, 32'h80001000}, 32'h80000008, 32'h80000008, 2'b01, '{1'b1, 32'h80001000}};
    vt[3] = '{32'hfffffff8, 2'b11, '{1'b0, 32'hdeadbeef}, 32'hfffffff8, 32'hfffffff8, 2'b11, '{1'b0, 32'hdeadbeef}};

    rst_n = 1'b0; flush_i = 1'b0; bpu_pc_i = '0; bpu_valid_i = '0; bpu_predict_i = '0;
    req_ready_i = 1'b0; resp_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    to_neg();
    chk("rst_stall", 64'(bpu_stall_o), 64'd0);
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    next();
    rst_n = 1'b1;
    next();

    // T1: single-group round trips from the vector table
    for (int i = 0; i < 4; i++) begin
      bpu_pc_i = vt[i].pc; bpu_valid_i = vt[i].mask; bpu_predict_i = vt[i].pred;
      to_neg();
      chk("t1_no_same_cycle_issue", 64'(req_valid_o), 64'd0);
      next();
      bpu_valid_i = 2'b00; req_ready_i = 1'b1;
      to_neg();
      chk("t1_req_valid", 64'(req_valid_o), 64'd1);
      chk("t1_req_pc", 64'(req_pc_o), 64'(vt[i].exp_req_pc));
      next();
      req_ready_i = 1'b0;
      next();
      resp_valid_i = 1'b1;
      to_neg();
      chk("t1_out_valid", 64'(out_valid_o), 64'd1);
      chk("t1_out_pc", 64'(out_pc_o), 64'(vt[i].exp_out_pc));
      chk("t1_out_mask", 64'(out_mask_o), 64'(vt[i].exp_out_mask));
      chk("t1_out_pred", 64'(out_predict_o), 64'(vt[i].exp_out_pred));
      next();
      resp_valid_i = 1'b0;
    end

    // T2: fill to full, overflow push dropped, stall releases after retire
    for (int i = 0; i < 8; i++) push(32'h1c001000 + 32'(i * 8), 2'b11);
    bpu_pc_i = 32'h1c00fff8; bpu_valid_i = 2'b11;
    to_neg();
    chk("t2_stall_full", 64'(bpu_stall_o), 64'd1);
    next();
    bpu_valid_i = 2'b00; req_ready_i = 1'b1;
    to_neg();
    chk("t2_req_pc", 64'(req_pc_o), 64'h1c001000);
    next();
    req_ready_i = 1'b0; resp_valid_i = 1'b1;
    to_neg();
    chk("t2_out_pc", 64'(out_pc_o), 64'h1c001000);
    chk("t2_stall_same_cycle", 64'(bpu_stall_o), 64'd1);
    next();
    resp_valid_i = 1'b0;
    to_neg();
    chk("t2_stall_released", 64'(bpu_stall_o), 64'd0);
    next();
    drain();

    // T3: flush with 3 in flight, 3 responses discarded, 4th is the new group
    for (int i = 0; i < 3; i++) push(32'h1c002000 + 32'(i * 8), 2'b11);
    req_ready_i = 1'b1;
    repeat (3) next();
    req_ready_i = 1'b0; flush_i = 1'b1;
    to_neg();
    chk("t3_flush_req_valid", 64'(req_valid_o), 64'd0);
    next();
    flush_i = 1'b0; bpu_pc_i = 32'h1c000100; bpu_valid_i = 2'b11; resp_valid_i = 1'b1;
    to_neg();
    chk("t3_disc1", 64'(out_valid_o), 64'd0);
    next();
    bpu_valid_i = 2'b00; req_ready_i = 1'b1;
    to_neg();
    chk("t3_disc2", 64'(out_valid_o), 64'd0);
    chk("t3_new_req", 64'(req_pc_o), 64'h1c000100);
    next();
    req_ready_i = 1'b0;
    to_neg();
    chk("t3_disc3", 64'(out_valid_o), 64'd0);
    next();
    to_neg();
    chk("t3_live_valid", 64'(out_valid_o), 64'd1);
    chk("t3_live_pc", 64'(out_pc_o), 64'h1c000100);
    next();
    resp_valid_i = 1'b0;

    // T4a: flush coincident with a response, 2 in flight -> 1 discard
    push(32'h1c002800, 2'b01);
    push(32'h1c002808, 2'b10);
    req_ready_i = 1'b1;
    repeat (2) next();
    req_ready_i = 1'b0; flush_i = 1'b1; resp_valid_i = 1'b1;
    to_neg();
    chk("t4_flush_out_valid", 64'(out_valid_o), 64'd0);
    next();
    flush_i = 1'b0; resp_valid_i = 1'b0;
    push(32'h1c003000, 2'b11);
    req_ready_i = 1'b1;
    next();
    req_ready_i = 1'b0; resp_valid_i = 1'b1;
    to_neg();
    chk("t4_one_discard", 64'(out_valid_o), 64'd0);
    next();
    to_neg();
    chk("t4_live_pc", 64'(out_pc_o), 64'h1c003000);
    chk("t4_live_valid", 64'(out_valid_o), 64'd1);
    next();
    resp_valid_i = 1'b0;

    // T4b: flush while a request would fire -> forced low, not counted
    push(32'h1c004000, 2'b11);
    req_ready_i = 1'b1; flush_i = 1'b1;
    to_neg();
    chk("t4_fire_flush_req_valid", 64'(req_valid_o), 64'd0);
    next();
    flush_i = 1'b0; req_ready_i = 1'b0;
    push(32'h1c005000, 2'b11);
    req_ready_i = 1'b1;
    next();
    req_ready_i = 1'b0; resp_valid_i = 1'b1;
    to_neg();
    chk("t4_no_phantom_discard", 64'(out_valid_o), 64'd1);
    chk("t4b_pc", 64'(out_pc_o), 64'h1c005000);
    next();
    resp_valid_i = 1'b0;

    // T5: 5 discards pending caps new issues at 3
    for (int i = 0; i < 5; i++) push(32'h1c006000 + 32'(i * 8), 2'b11);
    req_ready_i = 1'b1;
    repeat (5) next();
    req_ready_i = 1'b0; flush_i = 1'b1;
    next();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h1c007000 + 32'(i * 8), 2'b11);
    req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t5_issue_allowed", 64'(req_valid_o), 64'd1);
      next();
    end
    to_neg();
    chk("t5_issue_capped", 64'(req_valid_o), 64'd0);
    next();
    resp_valid_i = 1'b1;
    to_neg();
    chk("t5_discard_resp", 64'(out_valid_o), 64'd0);
    chk("t5_still_capped", 64'(req_valid_o), 64'd0);
    next();
    resp_valid_i = 1'b0;
    to_neg();
    chk("t5_uncapped", 64'(req_valid_o), 64'd1);
    chk("t5_uncapped_pc", 64'(req_pc_o), 64'h1c007018);
    next();
    drain();

    // T6: random concurrent push/issue/retire around half full
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() < 4 || $urandom_range(0, 3) == 0) begin
        bpu_pc_i = {$urandom_range(0, 32'h0fffffff), 3'b000} | 32'h10000000;
        bpu_valid_i = 2'($urandom_range(1, 3));
        bpu_predict_i = '{taken: 1'($urandom_range(0, 1)), target: $urandom};
      end else bpu_valid_i = 2'b00;
      req_ready_i = ($urandom_range(0, 3) != 0);
      resp_valid_i = (tb_disc + tb_infl != 0) && ($urandom_range(0, 2) != 0);
      next();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
